// File: rtl/dmem_access_unit_if.sv
// Word-wide data memory bus between the load/store unit (master) and memory (slave).
// The slave accepts a request with mem_ready, then returns load data with mem_rvalid.
interface dmem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_ready,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_ready,
    output mem_rvalid,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store unit: store lane steering, load extraction/extension,
// pipeline stall across the bus transaction, misalignment and timeout flags.
module dmem_access_unit #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid,
  input  logic                       DMEM_RW,
  input  logic [1:0]                 access_size,
  input  logic                       load_unsigned,
  input  logic [31:0]                addr,
  input  logic [31:0]                store_data,
  output logic                       stall,
  output logic                       resp_valid,
  output logic [31:0]                load_data,
  output logic                       misaligned,
  output logic                       bus_error,
  dmem_access_unit_if.master         bus
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [1:0]  offset_q, offset_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        resp_valid_q, resp_valid_d;
  logic        misaligned_q, misaligned_d;
  logic        bus_error_q, bus_error_d;
  logic [31:0] load_data_q, load_data_d;

  logic        aligned;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;
  logic [31:0] rdata_shifted;
  logic [31:0] load_ext;

  always_comb begin
    case (access_size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr[0];
      default: aligned = (addr[1:0] == 2'b00);
    endcase
  end

  // Each byte lane picks its source byte and strobe from the access size and offset.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_wdata[8*gi +: 8] =
        (access_size == 2'b00) ? store_data[7:0] :
        (access_size == 2'b01) ? store_data[8*(gi%2) +: 8] :
                                 store_data[8*gi +: 8];
    assign lane_wstrb[gi] =
        (access_size == 2'b00) ? (addr[1:0] == 2'(gi)) :
        (access_size == 2'b01) ? (addr[1] == 1'(gi/2)) :
                                 1'b1;
  end

  assign rdata_shifted = bus.mem_rdata >> {offset_q, 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'd0, rdata_shifted[7:0]}
                                : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      2'b01:   load_ext = uns_q ? {16'd0, rdata_shifted[15:0]}
                                : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: load_ext = rdata_shifted;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    offset_d     = offset_q;
    size_d       = size_q;
    uns_d        = uns_q;
    cnt_d        = cnt_q;
    load_data_d  = load_data_q;
    resp_valid_d = 1'b0;
    misaligned_d = 1'b0;
    bus_error_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (!aligned) begin
            misaligned_d = 1'b1;
          end else begin
            state_d     = ST_ISSUE;
            mem_req_d   = 1'b1;
            mem_we_d    = DMEM_RW;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wdata_d = lane_wdata;
            mem_wstrb_d = DMEM_RW ? lane_wstrb : 4'b0000;
            offset_d    = addr[1:0];
            size_d      = access_size;
            uns_d       = load_unsigned;
            cnt_d       = 8'd0;
          end
        end
      end

      ST_ISSUE: begin
        if (bus.mem_ready) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (mem_we_q) begin
            state_d      = ST_DONE;
            resp_valid_d = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        // Returned data takes priority over a timeout landing on the same cycle.
        if (bus.mem_rvalid) begin
          state_d      = ST_DONE;
          load_data_d  = load_ext;
          resp_valid_d = 1'b1;
          cnt_d        = 8'd0;
        end else if ((cnt_q + 8'd1) == MAX_WAIT_C) begin
          state_d      = ST_DONE;
          load_data_d  = 32'd0;
          resp_valid_d = 1'b1;
          bus_error_d  = 1'b1;
          cnt_d        = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      mem_wstrb_q  <= 4'b0000;
      offset_q     <= 2'b00;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      cnt_q        <= 8'd0;
      resp_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
      load_data_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      offset_q     <= offset_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      misaligned_q <= misaligned_d;
      bus_error_q  <= bus_error_d;
      load_data_q  <= load_data_d;
    end
  end

  assign stall = ((state_q == ST_IDLE) && req_valid && aligned)
               || (state_q == ST_ISSUE) || (state_q == ST_WAIT);

  assign resp_valid    = resp_valid_q;
  assign load_data     = load_data_q;
  assign misaligned    = misaligned_q;
  assign bus_error     = bus_error_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed scenarios plus randomized accesses against
// a cycle-timeline reference model with a scripted memory responder.
module tb_dmem_access_unit;
  localparam int MAXW = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        DMEM_RW;
  logic [1:0]  access_size;
  logic        load_unsigned;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic        resp_valid;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_error;

  int checks = 0;
  int errors = 0;
  int txn_id = 0;

  always #5 clock = ~clock;

  dmem_access_unit_if bus ();

  dmem_access_unit #(.MAX_WAIT(MAXW)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .DMEM_RW       (DMEM_RW),
    .access_size   (access_size),
    .load_unsigned (load_unsigned),
    .addr          (addr),
    .store_data    (store_data),
    .stall         (stall),
    .resp_valid    (resp_valid),
    .load_data     (load_data),
    .misaligned    (misaligned),
    .bus_error     (bus_error),
    .bus           (bus.master)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_aligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 1'b1;
    if (sz == 2'd1) return (a % 2) == 0;
    return (a % 4) == 0;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] sd);
    if (sz == 2'd0) return 32'(sd[7:0]) * 32'h0101_0101;
    if (sz == 2'd1) return 32'(sd[15:0]) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [3:0] model_wstrb(input logic [1:0] sz, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return (off >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns,
                                             input logic [31:0] a, input logic [31:0] w);
    int b [4];
    int off;
    int v;
    for (int i = 0; i < 4; i++) b[i] = int'(w[8*i +: 8]);
    off = int'(a % 4);
    if (sz == 2'd0) begin
      v = b[off];
      if (!uns && v >= 128) v -= 256;
    end else if (sz == 2'd1) begin
      v = b[off] + 256 * b[off + 1];
      if (!uns && v >= 32768) v -= 65536;
    end else begin
      return w;
    end
    return 32'(v);
  endfunction

  task automatic idle_cycles(input int n, input bit late_rvalid);
    for (int c = 0; c < n; c++) begin
      req_valid      = 1'b0;
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = late_rvalid ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.mem_rdata  = $urandom;
      @(negedge clock);
      check("idle_stall", 32'(stall), 32'd0);
      check("idle_resp_valid", 32'(resp_valid), 32'd0);
      check("idle_mem_req", 32'(bus.mem_req), 32'd0);
      check("idle_misaligned", 32'(misaligned), 32'd0);
      @(posedge clock); #1;
    end
    bus.mem_rvalid = 1'b0;
  endtask

  // rd: ISSUE cycles before mem_ready; rv: WAIT cycles before mem_rvalid (>= MAXW means never).
  task automatic run_txn(input bit rw, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] sd,
                         input int rd, input int rv, input logic [31:0] rdata, input bit noisy);
    bit          al;
    bit          timeout;
    int          resp;
    bit          in_issue;
    logic [31:0] exp_ld;

    txn_id++;
    DMEM_RW       = rw;
    access_size   = sz;
    load_unsigned = uns;
    addr          = a;
    store_data    = sd;
    al            = model_aligned(sz, a);

    if (!al) begin
      req_valid      = 1'b1;
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      @(negedge clock);
      check("mis_stall_c0", 32'(stall), 32'd0);
      check("mis_pulse_c0", 32'(misaligned), 32'd0);
      check("mis_mem_req_c0", 32'(bus.mem_req), 32'd0);
      @(posedge clock); #1;
      req_valid = 1'b0;
      @(negedge clock);
      check("mis_pulse_c1", 32'(misaligned), 32'd1);
      check("mis_stall_c1", 32'(stall), 32'd0);
      check("mis_mem_req_c1", 32'(bus.mem_req), 32'd0);
      check("mis_resp_valid", 32'(resp_valid), 32'd0);
      @(posedge clock); #1;
      $display("txn %0d %s size=%0d addr=%h misaligned dropped", txn_id, rw ? "ST" : "LD", sz, a);
      return;
    end

    timeout = !rw && (rv >= MAXW);
    if (rw)           resp = 2 + rd;
    else if (timeout) resp = 2 + rd + MAXW;
    else              resp = 3 + rd + rv;
    exp_ld = timeout ? 32'd0 : model_load(sz, uns, a, rdata);

    for (int c = 0; c <= resp; c++) begin
      in_issue       = (c >= 1) && (c <= 1 + rd);
      req_valid      = 1'b1;
      bus.mem_ready  = (c == 1 + rd);
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
      if (!rw && !timeout && c == 2 + rd + rv) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
      end else if (noisy && in_issue) begin
        bus.mem_rvalid = 1'($urandom_range(0, 1));
      end
      @(negedge clock);
      check("stall", 32'(stall), 32'(c < resp));
      check("resp_valid", 32'(resp_valid), 32'(c == resp));
      check("mem_req", 32'(bus.mem_req), 32'(in_issue));
      check("misaligned", 32'(misaligned), 32'd0);
      if (in_issue) begin
        check("mem_addr", bus.mem_addr, {a[31:2], 2'b00});
        check("mem_we", 32'(bus.mem_we), 32'(rw));
        check("mem_wstrb", 32'(bus.mem_wstrb), rw ? 32'(model_wstrb(sz, a)) : 32'd0);
        if (rw) check("mem_wdata", bus.mem_wdata, model_wdata(sz, sd));
      end
      if (c == resp) begin
        check("bus_error", 32'(bus_error), 32'(timeout));
        if (!rw) check("load_data", load_data, exp_ld);
      end else begin
        check("bus_error_quiet", 32'(bus_error), 32'd0);
      end
      @(posedge clock); #1;
    end
    req_valid      = 1'b0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    $display("txn %0d %s size=%0d uns=%0d addr=%h sd=%h rdy_dly=%0d rv_dly=%0d exp_ld=%h tmo=%0d",
             txn_id, rw ? "ST" : "LD", sz, uns, a, sd, rd, rv, exp_ld, timeout);
  endtask

  // Reset during ISSUE (mem_ready withheld) or during WAIT, then a late rvalid must be ignored.
  task automatic reset_mid(input bit in_wait);
    txn_id++;
    DMEM_RW        = 1'b0;
    access_size    = 2'b10;
    load_unsigned  = 1'b0;
    addr           = 32'h0000_0300;
    store_data     = 32'd0;
    req_valid      = 1'b1;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    @(negedge clock);
    check("rst_stall_c0", 32'(stall), 32'd1);
    @(posedge clock); #1;
    bus.mem_ready = in_wait;
    if (!in_wait) reset = 1'b1;
    @(negedge clock);
    check("rst_mem_req_issue", 32'(bus.mem_req), 32'd1);
    @(posedge clock); #1;
    bus.mem_ready = 1'b0;
    if (in_wait) begin
      reset = 1'b1;
      @(negedge clock);
      check("rst_stall_wait", 32'(stall), 32'd1);
      check("rst_mem_req_wait", 32'(bus.mem_req), 32'd0);
      @(posedge clock); #1;
    end
    reset     = 1'b0;
    req_valid = 1'b0;
    @(negedge clock);
    check("rst_mem_req_after", 32'(bus.mem_req), 32'd0);
    check("rst_stall_after", 32'(stall), 32'd0);
    check("rst_resp_after", 32'(resp_valid), 32'd0);
    @(posedge clock); #1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE_F00D;
    @(negedge clock);
    @(posedge clock); #1;
    bus.mem_rvalid = 1'b0;
    @(negedge clock);
    check("rst_late_rvalid_resp", 32'(resp_valid), 32'd0);
    check("rst_late_rvalid_load_data", load_data, 32'd0);
    @(posedge clock); #1;
    $display("txn %0d reset during %s abandoned", txn_id, in_wait ? "WAIT" : "ISSUE");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    req_valid      = 1'b0;
    DMEM_RW        = 1'b0;
    access_size    = 2'b00;
    load_unsigned  = 1'b0;
    addr           = 32'd0;
    store_data     = 32'd0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'd0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_load_data", load_data, 32'd0);
    check("reset_misaligned", 32'(misaligned), 32'd0);
    check("reset_bus_error", 32'(bus_error), 32'd0);
    check("reset_mem_req", 32'(bus.mem_req), 32'd0);
    check("reset_mem_we", 32'(bus.mem_we), 32'd0);
    check("reset_mem_addr", bus.mem_addr, 32'd0);
    check("reset_mem_wdata", bus.mem_wdata, 32'd0);
    check("reset_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    @(posedge clock); #1;

    // Directed scenarios
    run_txn(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 32'd0, 1'b0);
    run_txn(1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_00A5, 0, 0, 32'd0, 1'b0);
    run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0202, 32'd0, 0, 0, 32'h12FF_3456, 1'b0);
    run_txn(1'b0, 2'b00, 1'b1, 32'h0000_0202, 32'd0, 0, 0, 32'h12FF_3456, 1'b0);
    run_txn(1'b0, 2'b01, 1'b0, 32'h0000_0201, 32'd0, 0, 0, 32'd0, 1'b0);
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'd0, 3, 2, 32'h8765_4321, 1'b1);
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0404, 32'd0, 0, MAXW + 3, 32'd0, 1'b0);
    run_txn(1'b0, 2'b01, 1'b0, 32'h0000_0406, 32'd0, 1, MAXW - 1, 32'h9ABC_0000, 1'b0);
    run_txn(1'b1, 2'b01, 1'b0, 32'h0000_0502, 32'h1234_5678, 2, 0, 32'd0, 1'b1);
    run_txn(1'b1, 2'b11, 1'b0, 32'h0000_0508, 32'h0BAD_F00D, 1, 0, 32'd0, 1'b0);
    idle_cycles(2, 1'b1);
    reset_mid(1'b1);
    reset_mid(1'b0);

    // Randomized accesses with a scripted responder and noise on idle/issue cycles
    for (int t = 0; t < 150; t++) begin
      logic [1:0]  r_sz;
      logic [31:0] r_addr;
      r_sz   = 2'($urandom_range(0, 3));
      r_addr = $urandom;
      if ($urandom_range(0, 3) != 0) r_addr[1:0] = (r_sz == 2'd0) ? r_addr[1:0]
                                                  : (r_sz == 2'd1) ? {r_addr[1], 1'b0} : 2'b00;
      run_txn(1'($urandom_range(0, 1)), r_sz, 1'($urandom_range(0, 1)), r_addr, $urandom,
              $urandom_range(0, 3), $urandom_range(0, MAXW + 1), $urandom, 1'b1);
      idle_cycles($urandom_range(0, 2), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Load/store unit between the MEM stage and the word-wide data memory bus. It consumes the decoder's `DMEM_RW` and `access_size` controls together with the effective address and rs2 data. It aligns store bytes onto lanes and strobes, extracts and sign- or zero-extends load data, and stalls the pipeline until the multi-cycle bus transaction completes. It also flags misaligned accesses and bus timeouts.

## Interface
Parameters:
- `MAX_WAIT`, default 15: WAIT-state cycles without `mem_rvalid` before a load is aborted with `bus_error`. Range 1..255.

Ports:
- `clock`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  1  MEM stage holds a load/store; inputs stable while `stall`=1
- `DMEM_RW`  in  1  1=store, 0=load
- `access_size`  in  2  00 byte, 01 half, 10 word, 11 treated as word
- `load_unsigned`  in  1  funct3[2]; zero-extend loads when 1
- `addr`  in  32  effective byte address
- `store_data`  in  32  rs2 value
- `stall`  out  1  hold pipeline (combinational)
- `resp_valid`  out  1  one-cycle completion pulse
- `load_data`  out  32  extended load result, valid with `resp_valid`
- `misaligned`  out  1  one-cycle pulse, access dropped
- `bus_error`  out  1  one-cycle pulse with `resp_valid` on timeout
- `mem_req`  out  1  bus request, held until `mem_ready`
- `mem_we`  out  1  bus write enable
- `mem_addr`  out  32  `{addr[31:2],2'b00}`
- `mem_wdata`  out  32  lane-replicated store data
- `mem_wstrb`  out  4  byte enables (0000 for loads)
- `mem_ready`  in  1  request accepted this cycle
- `mem_rvalid`  in  1  read data valid
- `mem_rdata`  in  32  read word

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- Alignment: half needs `addr[0]`=0; word/11 needs `addr[1:0]`=00; byte is always aligned.
- IDLE behaviour:
  - `req_valid` and misaligned: pulse `misaligned` next cycle, stay IDLE, no bus activity.
  - `req_valid` and aligned: register `mem_addr`, `mem_we`, `mem_wdata`, `mem_wstrb`, offset `addr[1:0]`, size and unsigned flag; go to ISSUE.
- ISSUE: `mem_req`=1. On `mem_ready`: a store goes to DONE, a load goes to WAIT. `mem_rvalid` in ISSUE is ignored.
- WAIT: counter increments each cycle.
  - `mem_rvalid`: latch the extracted data and go to DONE.
  - Counter reaches `MAX_WAIT` without `mem_rvalid`: go to DONE with `load_data`=0 and `bus_error`=1.
  - `mem_rvalid` on the timeout cycle: the data wins and there is no error.
- DONE: `resp_valid`=1 for one cycle, then IDLE. `req_valid` is ignored in DONE because those inputs still belong to the completed access.
- Store lanes:
  - byte: wdata `{4{sd[7:0]}}`, wstrb `4'b0001<<addr[1:0]`
  - half: wdata `{2{sd[15:0]}}`, wstrb 0011 if `addr[1]`=0, else 1100
  - word: wdata `sd`, wstrb 1111
- Load extract: shift `mem_rdata` right by 8*offset, take 8/16/32 bits, sign-extend unless `load_unsigned`. The unsigned flag is ignored for word.
- `stall` = (IDLE & `req_valid` & aligned) | ISSUE | WAIT.

## Timing
- Reset: state IDLE; `mem_req`, `mem_we`, `resp_valid`, `misaligned`, `bus_error` are 0; `mem_addr`, `mem_wdata`, `load_data` are 0; `mem_wstrb`=0000; counter 0.
- Reset mid-transaction abandons the access: `mem_req` is 0 the next cycle, and a late `mem_rvalid` in IDLE is ignored.
- All bus outputs are registered and stable while `mem_req`=1 and `mem_ready`=0.
- Store, `mem_ready` immediate: cycle 0 IDLE sample, cycle 1 ISSUE, cycle 2 DONE. `stall` high in cycles 0–1.
- Load, ready immediate, `mem_rvalid` in the first WAIT cycle: DONE in cycle 3. `stall` high in cycles 0–2.
- Misaligned: `misaligned` high in cycle 1; `stall` never asserted.

## Test plan
- Word store to 0x100, data 0xDEADBEEF, `mem_ready` immediate -> `mem_addr`=0x100, `mem_wstrb`=1111, `resp_valid` in cycle 2, `stall` high for 2 cycles.
- Byte store to 0x103, data 0x000000A5 -> `mem_wdata`=0xA5A5A5A5, `mem_wstrb`=1000.
- LB, then LBU, at 0x202 with `mem_rdata`=0x12FF3456 -> `load_data`=0xFFFFFFFF, then 0x000000FF.
- LH at 0x201 -> `misaligned` pulse, `mem_req` stays 0, `stall`=0.
- LW with `mem_ready` delayed 3 cycles and `mem_rvalid` after 2 more -> bus outputs held throughout; `resp_valid` exactly once with the correct word.
- Load with `mem_rvalid` never asserted, `MAX_WAIT`=4 -> `bus_error` and `resp_valid` after 4 WAIT cycles, `load_data`=0; in a second run, `reset` asserted in WAIT drops `mem_req` to 0 the next cycle.
